onehot_class_counter: RTL and testbench

Downstream consumer of the 4-to-8 priority class decoder. It takes the decoder's one-hot class code (bits 3:0 carry classes 0-3; bits 7:4 are always zero) and keeps one saturating event counter per class. On request it snapshots all four counts and streams them out over a valid/ready interface, one count per transfer. Counting continues while the stream is in progress.

---
 rtl/onehot_class_counter.sv | 133 +++++++++++++
 tb/tb_onehot_class_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_class_counter.sv
// Per-class saturating event counters fed by a one-hot class code, with snapshot stream-out over valid/ready.
// Optional CLASS_CNT_CLEAR_ON_DUMP_EN: reload counters on an accepted dump (interval counting).
module onehot_class_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  input  logic             clr,
  input  logic             dump_req,
  output logic [CNT_W-1:0] dout,
  output logic [1:0]       dout_idx,
  output logic             dout_valid,
  output logic             dout_last,
  input  logic             dout_ready,
  output logic             busy,
  output logic             err
);

  localparam int unsigned NCLS = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt  [NCLS];
  logic [CNT_W-1:0] r_snap [NCLS];
  logic [CNT_W-1:0] r_dout;
  logic [1:0]       r_idx;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_err;

  logic             w_legal;
  logic [1:0]       w_cls;
  logic             w_inc;
  logic             w_bad;
  logic             w_dump;
  logic [1:0]       w_nidx;

  // Decode the one-hot code; anything outside the four legal values is an error
  always_comb begin
    w_legal = 1'b0;
    w_cls   = 2'd0;
    case (code_in)
      8'h01: begin w_legal = 1'b1; w_cls = 2'd0; end
      8'h02: begin w_legal = 1'b1; w_cls = 2'd1; end
      8'h04: begin w_legal = 1'b1; w_cls = 2'd2; end
      8'h08: begin w_legal = 1'b1; w_cls = 2'd3; end
      default: begin w_legal = 1'b0; w_cls = 2'd0; end
    endcase
  end

  assign w_inc  = code_valid & w_legal;
  assign w_bad  = code_valid & ~w_legal;
  assign w_dump = (r_state == S_IDLE) & dump_req;
  assign w_nidx = r_idx + 2'd1;

  // Counters and sticky error; clr wins over increment and error set
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCLS; k++) r_cnt[k] <= '0;
      r_err <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < NCLS; k++) r_cnt[k] <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_bad) r_err <= 1'b1;
      for (int k = 0; k < NCLS; k++) begin
`ifdef CLASS_CNT_CLEAR_ON_DUMP_EN
        if (w_dump)
          r_cnt[k] <= (w_inc && (w_cls == 2'(k))) ? CNT_W'(1) : '0;
        else
`endif
        if (w_inc && (w_cls == 2'(k)) && (r_cnt[k] != CNT_MAX))
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  // Snapshot/stream FSM; snapshot takes pre-edge counter values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      for (int k = 0; k < NCLS; k++) r_snap[k] <= '0;
      r_dout  <= '0;
      r_idx   <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            for (int k = 0; k < NCLS; k++) r_snap[k] <= r_cnt[k];
            r_dout  <= r_cnt[0];
            r_idx   <= 2'd0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (dout_ready) begin
            if (r_idx == 2'd3) begin
              r_idx   <= 2'd0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx  <= w_nidx;
              r_dout <= r_snap[w_nidx];
              r_last <= (w_nidx == 2'd3);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_idx   = r_idx;
  assign dout_valid = r_valid;
  assign dout_last  = r_last;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_onehot_class_counter.sv
// Self-checking bench: two widths (8 and 4) driven in parallel against a behavioural model.
module tb_onehot_class_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code_in = 8'h00;
  logic       code_valid = 1'b0;
  logic       clr = 1'b0;
  logic       dump_req = 1'b0;
  logic       dout_ready = 1'b0;

  logic [7:0] a_dout;  logic [1:0] a_idx;  logic a_valid, a_last, a_busy, a_err;
  logic [3:0] b_dout;  logic [1:0] b_idx;  logic b_valid, b_last, b_busy, b_err;

  int n_vec = 0;
  int n_bad = 0;

  onehot_class_counter #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .clr(clr),
    .dump_req(dump_req), .dout(a_dout), .dout_idx(a_idx), .dout_valid(a_valid),
    .dout_last(a_last), .dout_ready(dout_ready), .busy(a_busy), .err(a_err));

  onehot_class_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .clr(clr),
    .dump_req(dump_req), .dout(b_dout), .dout_idx(b_idx), .dout_valid(b_valid),
    .dout_last(b_last), .dout_ready(dout_ready), .busy(b_busy), .err(b_err));

  always #5 clk = ~clk;

  // Model: plain per-class integers, saturated per width
  int  m_cnt  [2][4];
  int  m_snap [2][4];
  int  m_max  [2] = '{255, 15};
  bit  m_err, m_busy;
  int  m_idx;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int  cls;
    bit  legal, acc;
    cls = 0; legal = 1'b0;
    for (int k = 0; k < 4; k++) if (code_in == 8'(1 << k)) begin legal = 1'b1; cls = k; end
    if (rst) begin
      for (int w = 0; w < 2; w++) for (int k = 0; k < 4; k++) begin m_cnt[w][k] = 0; m_snap[w][k] = 0; end
      m_err = 0; m_busy = 0; m_idx = 0;
      return;
    end
    acc = !m_busy && dump_req;
    if (acc) begin
      for (int w = 0; w < 2; w++) for (int k = 0; k < 4; k++) m_snap[w][k] = m_cnt[w][k];
      m_busy = 1; m_idx = 0;
    end else if (m_busy && dout_ready) begin
      if (m_idx == 3) begin m_busy = 0; m_idx = 0; end
      else m_idx++;
    end
    if (clr) begin
      for (int w = 0; w < 2; w++) for (int k = 0; k < 4; k++) m_cnt[w][k] = 0;
      m_err = 0;
    end else begin
      if (code_valid && !legal) m_err = 1;
      for (int w = 0; w < 2; w++) begin
`ifdef CLASS_CNT_CLEAR_ON_DUMP_EN
        if (acc) for (int k = 0; k < 4; k++) m_cnt[w][k] = 0;
`endif
        if (code_valid && legal && m_cnt[w][cls] < m_max[w]) m_cnt[w][cls]++;
      end
    end
  endtask

  task automatic compare();
    chk("w8_valid", int'(a_valid), int'(m_busy));
    chk("w8_busy",  int'(a_busy),  int'(m_busy));
    chk("w8_idx",   int'(a_idx),   m_idx);
    chk("w8_last",  int'(a_last),  int'(m_busy && m_idx == 3));
    chk("w8_err",   int'(a_err),   int'(m_err));
    chk("w4_valid", int'(b_valid), int'(m_busy));
    chk("w4_busy",  int'(b_busy),  int'(m_busy));
    chk("w4_idx",   int'(b_idx),   m_idx);
    chk("w4_last",  int'(b_last),  int'(m_busy && m_idx == 3));
    chk("w4_err",   int'(b_err),   int'(m_err));
    if (m_busy) begin
      chk("w8_dout", int'(a_dout), m_snap[0][m_idx]);
      chk("w4_dout", int'(b_dout), m_snap[1][m_idx]);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare just after the edge
  task automatic cyc(input logic [7:0] c, input logic cv, input logic cl,
                     input logic dr, input logic rd, input logic rs);
    code_in = c; code_valid = cv; clr = cl; dump_req = dr; dout_ready = rd; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic ev(input logic [7:0] c);
    cyc(c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rd);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, rd, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && a_busy; i++) idle(1'b1);
    chk("drain_done", int'(a_busy), 0);
  endtask

  int r;
  logic [7:0] rc;

  initial begin
    // Reset
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_busy",  int'(a_busy), 0);
    chk("rst_err",   int'(a_err), 0);

    // Basic counting and back-to-back stream
    ev(8'h01); ev(8'h02); ev(8'h02); ev(8'h04); ev(8'h04); ev(8'h04);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t1_d0", int'(a_dout), 1); chk("t1_i0", int'(a_idx), 0); chk("t1_l0", int'(a_last), 0);
    idle(1'b1);
    chk("t1_d1", int'(a_dout), 2); chk("t1_i1", int'(a_idx), 1);
    idle(1'b1);
    chk("t1_d2", int'(a_dout), 3); chk("t1_i2", int'(a_idx), 2);
    idle(1'b1);
    chk("t1_d3", int'(a_dout), 0); chk("t1_i3", int'(a_idx), 3); chk("t1_l3", int'(a_last), 1);
    chk("t1_busy3", int'(a_busy), 1);
    idle(1'b1);
    chk("t1_end_valid", int'(a_valid), 0); chk("t1_end_busy", int'(a_busy), 0);

    // Saturation
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) ev(8'h08);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sat_w4_d0", int'(b_dout), 0);
    idle(1'b1); idle(1'b1); idle(1'b1);
    chk("sat_w4_d3", int'(b_dout), 15);
    chk("sat_w8_d3", int'(a_dout), 20);
    idle(1'b1);

    // Illegal codes and clear
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ev(8'h00);
    chk("err_00", int'(a_err), 1);
    ev(8'h30);
    chk("err_30", int'(b_err), 1);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_clr", int'(a_err), 0);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_d0", int'(a_dout), 0);
    drain();

    // Backpressure at idx 1, events and ignored dump_req during stream
    ev(8'h01); ev(8'h02);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("bp_idx", int'(a_idx), 1);
      chk("bp_dout", int'(a_dout), 1);
    end
    idle(1'b1); idle(1'b1);
    chk("bp_last", int'(a_last), 1);
    idle(1'b1);
    chk("bp_no_extra", int'(a_valid), 0);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef CLASS_CNT_CLEAR_ON_DUMP_EN
    chk("bp_second_d0", int'(a_dout), 3);
`else
    chk("bp_second_d0", int'(a_dout), 4);
`endif
    drain();

    // Dump on the same edge as a class-2 event
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ev(8'h04);
    cyc(8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    chk("same_d2", int'(a_dout), 5);
    idle(1'b1); idle(1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
`ifdef CLASS_CNT_CLEAR_ON_DUMP_EN
    chk("next_d2", int'(a_dout), 1);
`else
    chk("next_d2", int'(a_dout), 6);
`endif
    drain();

    // Reset mid-stream
    ev(8'h02); ev(8'h10);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    chk("mid_idx", int'(a_idx), 2);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mid_valid", int'(a_valid), 0); chk("mid_busy", int'(a_busy), 0); chk("mid_err", int'(a_err), 0);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mid_cnt0", int'(a_dout), 0);
    idle(1'b1);
    chk("mid_cnt1", int'(a_dout), 0);
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) rc = 8'(1 << (r % 4));
      else if (r == 8) rc = 8'h00;
      else rc = 8'($urandom);
      cyc(rc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
